// File: rtl/ps2_key_pkg.sv
// Shared PS/2 scancode constants, decoder state type and direction indices
// for ps2_dir_decoder and its per-direction auto-repeat helper.
package ps2_key_pkg;

  // Prefix bytes of the scancode set 2 stream
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Non-extended W/A/S/D keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  // Bit positions of each direction in the 4-bit held/step vectors
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;
  localparam int NUM_DIRS  = 4;

  // Prefix tracking: which of E0 / F0 has been seen ahead of the current byte
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  // One-hot direction mask for an extended arrow code, zero for anything else
  function automatic logic [NUM_DIRS-1:0] arrow_mask(input logic [7:0] code);
    arrow_mask = '0;
    case (code)
      SC_UP:    arrow_mask[DIR_UP]    = 1'b1;
      SC_DOWN:  arrow_mask[DIR_DOWN]  = 1'b1;
      SC_LEFT:  arrow_mask[DIR_LEFT]  = 1'b1;
      SC_RIGHT: arrow_mask[DIR_RIGHT] = 1'b1;
      default:  arrow_mask = '0;
    endcase
  endfunction

  // One-hot direction mask for a non-extended WASD code, zero for anything else
  function automatic logic [NUM_DIRS-1:0] wasd_mask(input logic [7:0] code);
    wasd_mask = '0;
    case (code)
      SC_W:    wasd_mask[DIR_UP]    = 1'b1;
      SC_S:    wasd_mask[DIR_DOWN]  = 1'b1;
      SC_A:    wasd_mask[DIR_LEFT]  = 1'b1;
      SC_D:    wasd_mask[DIR_RIGHT] = 1'b1;
      default: wasd_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_dir_repeat.sv
// Per-direction step generator: one pulse on the rising edge of 'held',
// then one pulse every REPEAT_CYCLES cycles while 'held' stays high.
// REPEAT_CYCLES must be >= 2 and 2**CNT_W must exceed REPEAT_CYCLES.
module ps2_dir_repeat #(
  parameter int REPEAT_CYCLES = 2500000,
  parameter int CNT_W         = 22
) (
  input  logic clock,
  input  logic reset,
  input  logic held,
  output logic step
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             held_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Edge detect and repeat cadence; the counter restarts on press and release
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    cnt_d = '0;
    step  = 1'b0;
    if (held && !held_q) begin
      step = 1'b1;
    end else if (held) begin
      if (cnt_q == CNT_LAST) begin
        step = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      held_q <= held;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 scancode stream to held direction levels plus auto-repeat step pulses.
// Holds the E0/F0 prefix FSM, the held-key registers and last_code; one
// ps2_dir_repeat instance per direction produces the step pulses.
// Optional: define PS2_WASD_EN to also decode W/A/S/D as a second held source.
module ps2_dir_decoder
  import ps2_key_pkg::*;
#(
  parameter int REPEAT_CYCLES = 2500000,
  parameter int CNT_W         = 22
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       step_up,
  output logic       step_down,
  output logic       step_left,
  output logic       step_right,
  output logic [7:0] last_code
);

  ps2_state_e          state_q, state_d;
  logic [NUM_DIRS-1:0] arrow_q, arrow_d;
  logic [7:0]          last_code_q;
  logic [NUM_DIRS-1:0] held;
  logic [NUM_DIRS-1:0] step_vec;
  logic [NUM_DIRS-1:0] code_arrow;

  assign code_arrow = arrow_mask(ps2_key_data);

`ifdef PS2_WASD_EN
  logic [NUM_DIRS-1:0] wasd_q, wasd_d;
  logic [NUM_DIRS-1:0] code_wasd;

  assign code_wasd = wasd_mask(ps2_key_data);
  assign held      = arrow_q | wasd_q;
`else
  assign held      = arrow_q;
`endif

  // Prefix FSM next state and held-bit updates, acting only on strobed bytes
  always_comb begin
    state_d = state_q;
    arrow_d = arrow_q;
`ifdef PS2_WASD_EN
    wasd_d  = wasd_q;
`endif
    if (ps2_key_pressed) begin
      case (state_q)
        IDLE: begin
          if (ps2_key_data == SC_EXT) begin
            state_d = EXT;
          end else if (ps2_key_data == SC_BRK) begin
            state_d = BRK;
          end else begin
            state_d = IDLE;
`ifdef PS2_WASD_EN
            wasd_d  = wasd_q | code_wasd;
`endif
          end
        end
        EXT: begin
          if (ps2_key_data == SC_BRK) begin
            state_d = EXT_BRK;
          end else if (ps2_key_data == SC_EXT) begin
            state_d = EXT;
          end else begin
            // A typematic make ORs in an already-set bit: level unchanged
            arrow_d = arrow_q | code_arrow;
            state_d = IDLE;
          end
        end
        BRK: begin
          if (ps2_key_data == SC_EXT) begin
            state_d = EXT;
          end else if (ps2_key_data == SC_BRK) begin
            state_d = BRK;
          end else begin
            state_d = IDLE;
`ifdef PS2_WASD_EN
            wasd_d  = wasd_q & ~code_wasd;
`endif
          end
        end
        EXT_BRK: begin
          arrow_d = arrow_q & ~code_arrow;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, held-key and debug-byte registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      arrow_q     <= '0;
      last_code_q <= '0;
`ifdef PS2_WASD_EN
      wasd_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      arrow_q <= arrow_d;
`ifdef PS2_WASD_EN
      wasd_q  <= wasd_d;
`endif
      if (ps2_key_pressed) begin
        last_code_q <= ps2_key_data;
      end
    end
  end

  // Independent step generator per direction
  for (genvar i = 0; i < NUM_DIRS; i++) begin : gen_dir
    ps2_dir_repeat #(
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_repeat (
      .clock (clock),
      .reset (reset),
      .held  (held[i]),
      .step  (step_vec[i])
    );
  end

  assign up         = held[DIR_UP];
  assign down       = held[DIR_DOWN];
  assign left       = held[DIR_LEFT];
  assign right      = held[DIR_RIGHT];
  assign step_up    = step_vec[DIR_UP];
  assign step_down  = step_vec[DIR_DOWN];
  assign step_left  = step_vec[DIR_LEFT];
  assign step_right = step_vec[DIR_RIGHT];
  assign last_code  = last_code_q;

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
- Converts the PS2 keyboard byte stream (ps2_key_data plus the ps2_key_pressed strobe) into the held direction levels up/down/left/right consumed by vga_controller.
- Also emits per-direction step pulses (one on press, then auto-repeat) for cursor or sprite movement.
- Sits between PS2_Interface and vga_controller at skeleton level, replacing the raw push-button direction inputs.

Parameters:
- REPEAT_CYCLES, 2500000: clock cycles between auto-repeat steps while a key is held (50 ms at 50 MHz); must be >=2.
- CNT_W, 22: repeat counter width; must satisfy 2^CNT_W > REPEAT_CYCLES.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- ps2_key_data  in  8  received scancode byte, valid when the strobe is high
- ps2_key_pressed  in  1  one-cycle strobe per received byte
- up, down, left, right  out  1 each  held-key levels
- step_up, step_down, step_left, step_right  out  1 each  one-cycle movement pulses
- last_code  out  8  most recent byte received, for seven-segment debug

Behaviour:
- Reset (async, reset=1): all outputs 0; FSM to IDLE; repeat counters 0. Reset mid-sequence discards any partial E0/F0 prefix.
- Bytes are acted on only in cycles where ps2_key_pressed=1. With the strobe in cycle N, all register updates are visible in cycle N+1.
- last_code loads every strobed byte.
- FSM states IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> IDLE (non-extended make code).
  - EXT: F0 -> EXT_BRK; E0 -> EXT; arrow code -> set held bit, -> IDLE; other -> IDLE.
  - BRK: E0 -> EXT (resync); F0 -> BRK; any other byte -> IDLE (break of non-extended key, no effect).
  - EXT_BRK: arrow code -> clear held bit, -> IDLE; other -> IDLE.
- Arrow codes (extended only): 75=up, 72=down, 6B=left, 74=right.
- Keyboard typematic repeats (a make for an already-held key) leave the held bit unchanged and do not restart the counter.
- Opposite directions may be held together; both outputs are asserted with no arbitration.
- Step generation, per direction and independent:
  - Held 0->1 in cycle N+1: step_x=1 in cycle N+1 and the counter clears to 0.
  - While held: the counter increments each cycle. When it equals REPEAT_CYCLES-1, step_x=1 for one cycle and the counter wraps to 0. The next steps therefore fall at N+1+k*REPEAT_CYCLES.
  - Held 1->0: counter clears to 0, no step that cycle.
  - A release and a new press of the same key cannot coincide, because one byte is processed per strobe.

Optional Feature:
- PS2_WASD_EN defined:
  - IDLE also decodes the non-extended makes 1D=up, 1C=left, 1B=down, 23=right and sets the bit; BRK decodes the same codes and clears it.
  - Each held output is the OR of arrow and WASD sources, each source tracked separately. Releasing one source while the other is held keeps the level at 1 and produces no new step.
- PS2_WASD_EN undefined: non-extended codes are ignored; the only held source is the arrow keys.

Decomposition:
- Package ps2_key_pkg:
  - constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP/SC_DOWN/SC_LEFT/SC_RIGHT, SC_W/SC_A/SC_S/SC_D;
  - FSM state typedef (2-bit enum);
  - direction index constants DIR_UP..DIR_RIGHT.
- Sub-module ps2_dir_repeat:
  - one instance per direction (4 total);
  - inputs clock, reset, held; output step;
  - contains the CNT_W counter and the edge detect.
- Top level holds the FSM, the held registers and last_code.

Test Plan:
All scenarios use REPEAT_CYCLES=8 in the bench.
- Strobe E0, 75 (strobe at cycle N for 75) -> up=1 at N+1; step_up=1 at N+1, N+9, N+17; last_code=8'h75.
- Hold up, then E0 F0 75 -> up=0 the cycle after 75, no further step_up, counter 0. Re-press -> step_up immediately.
- E0 74 sent twice (typematic) -> right stays 1 and step_right cadence is unchanged (no extra pulse).
- E0 6B, E0 74, then E0 F0 6B -> left and right both 1, then left=0 and right=1, right's step cadence undisturbed.
- Strobe E0, then assert reset, release, strobe 75 -> no held bit set (prefix lost). F0 E0 F0 72 with down held -> down=0 (BRK resync path).
- PS2_WASD_EN: 1D -> up=1; then E0 75 -> no new step; F0 1D -> up stays 1; E0 F0 75 -> up=0. Without the macro, 1D -> no change.
